senone_sequencer: RTL and testbench
===================================

SENONE_SEQUENCER -- requirements
Module: senone_sequencer

Interface
REQ-001 SHALL have parameter N_COMPONENTS, default 25, meaning Gaussian components per senone.
REQ-002 SHALL have parameter NUM_W, default 16, meaning width of each k/omega/mean word.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port nReset, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit; a pulse that requests a run.
REQ-006 SHALL have port abort, input, 1 bit; cancels an active run.
REQ-007 SHALL have ports first_idx and last_idx, input, 5 bits each; the inclusive senone range, sampled on an accepted start.
REQ-008 SHALL have port rom_index, output, 5 bits; drives the senone data ROM index.
REQ-009 SHALL have ports rom_k (NUM_W), rom_omegas and rom_means (N_COMPONENTS*NUM_W each), input; combinational ROM row, component c at bits [c*NUM_W +: NUM_W].
REQ-010 SHALL have ports comp_valid (output, 1), comp_ready (input, 1), comp_k, comp_omega, comp_mean (output, NUM_W each); the component stream to the scorer.
REQ-011 SHALL have ports comp_senone (output, 5), comp_idx (output, clog2(N_COMPONENTS)) and comp_last (output, 1); the stream tags, with comp_last marking the final component of a senone.
REQ-012 SHALL have ports busy (output, 1), done (output, 1-cycle pulse) and err (output, 1-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-014 In IDLE, start=1 with abort=0 SHALL latch the range, set rom_index=first_idx and enter LOAD next cycle; busy SHALL be high in LOAD, STREAM and DONE.
REQ-015 LOAD SHALL last exactly one cycle, register rom_k, rom_omegas and rom_means at its end, then enter STREAM with comp_idx=0.
REQ-016 In STREAM, comp_valid SHALL be 1 and comp_k, comp_omega, comp_mean and the tags SHALL be held stable until comp_valid && comp_ready.
REQ-017 Each transfer SHALL advance comp_idx by 1, from 0 upward; comp_last=1 iff comp_idx==N_COMPONENTS-1.
REQ-018 A transfer with comp_last and rom_index!=last_idx SHALL increment rom_index modulo 32 and enter LOAD, giving one comp_valid=0 bubble between senones.
REQ-019 A transfer with comp_last and rom_index==last_idx SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-020 Peak throughput SHALL be one component per cycle while comp_ready=1.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 abort=1 in LOAD, STREAM or DONE SHALL force IDLE next cycle with comp_valid=0 and no done pulse; abort takes priority over start and over a same-cycle transfer.
REQ-023 first_idx==last_idx SHALL stream exactly one senone.
REQ-024 comp_senone SHALL equal rom_index for the senone being streamed.

Reset
REQ-025 nReset low SHALL asynchronously force IDLE, rom_index=0, comp_idx=0, all registered data 0, and busy, done, err, comp_valid and comp_last all 0.
REQ-026 Reset mid-run SHALL discard the run; no done pulse SHALL follow reset release.

Configuration
REQ-027 With macro SENONE_SEQ_WRAP_EN defined, first_idx>last_idx SHALL be accepted, with indices running first_idx..31, 0..last_idx.
REQ-028 Without SENONE_SEQ_WRAP_EN, start with first_idx>last_idx SHALL pulse err for one cycle and remain in IDLE (busy=0).

Verification
REQ-029 Bench setup SHALL be N_COMPONENTS=4; ROM row 0 k=16'h17C5, omegas[3:0]={0011,0010,0014,002B}, means[3:0]={FADD,F9E4,0EF7,17A3}. Scenario: start with first=last=0 and comp_ready=1 -> LOAD 1 cycle, then 4 beats with comp_omega 002B,0014,0010,0011 and comp_mean 17A3,0EF7,F9E4,FADD; comp_k=17C5 on every beat; comp_last on beat 4; done one cycle later.
REQ-030 Range 0..2 with comp_ready=1 -> 12 beats, comp_senone 0,0,0,0,1..,2..; exactly one bubble cycle between senones; one done pulse.
REQ-031 Backpressure: comp_ready low for 3 cycles on beat 2 -> comp_omega stays 16'h0014 and comp_idx stays 1 throughout; no beat lost or duplicated.
REQ-032 abort asserted on beat 3 of senone 1 -> comp_valid=0 next cycle, busy=0, no done pulse; a following start then runs normally.
REQ-033 first=30, last=1 -> with SENONE_SEQ_WRAP_EN, senones 30,31,0,1 are streamed; without it, err pulses once and busy stays 0.
REQ-034 nReset asserted during STREAM -> all outputs 0 immediately, with no done pulse after release.

Source files
------------

// File: rtl/senone_sequencer.sv
// senone_sequencer
//   Walks an inclusive range of senone ROM rows and streams each row's
//   Gaussian components to the scorer, one component per valid/ready
//   transfer. Each row is fetched in a single LOAD cycle, registered,
//   and then streamed component by component.
//
// Build option:
//   SENONE_SEQ_WRAP_EN  defined   : first_idx > last_idx is accepted and the
//                                   index runs first_idx..31, 0..last_idx.
//                       undefined : first_idx > last_idx pulses err for one
//                                   cycle and the sequencer stays idle.
//
// Ports:
//   clk, nReset                      clock (rising edge), async active-low reset
//   start, abort                     run request pulse / cancel active run
//   first_idx, last_idx              inclusive senone range, sampled on start
//   rom_index                        senone ROM row address
//   rom_k, rom_omegas, rom_means     combinational ROM row, component c at
//                                    bits [c*NUM_W +: NUM_W]
//   comp_valid, comp_ready           component stream handshake
//   comp_k, comp_omega, comp_mean    component payload
//   comp_senone, comp_idx, comp_last stream tags
//   busy, done, err                  status; done and err are 1-cycle pulses
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; range check happens here
// LOAD  | ROM row addressed by rom_index is captured at the end of cycle
// STREAM| presenting component comp_idx of the captured row
// DONE  | last component of last senone sent; done pulses, back to IDLE
module senone_sequencer #(
    parameter int N_COMPONENTS = 25,
    parameter int NUM_W        = 16,
    localparam int IDX_W       = (N_COMPONENTS > 1) ? $clog2(N_COMPONENTS) : 1
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [4:0]                    first_idx,
    input  logic [4:0]                    last_idx,
    output logic [4:0]                    rom_index,
    input  logic [NUM_W-1:0]              rom_k,
    input  logic [N_COMPONENTS*NUM_W-1:0] rom_omegas,
    input  logic [N_COMPONENTS*NUM_W-1:0] rom_means,
    output logic                          comp_valid,
    input  logic                          comp_ready,
    output logic [NUM_W-1:0]              comp_k,
    output logic [NUM_W-1:0]              comp_omega,
    output logic [NUM_W-1:0]              comp_mean,
    output logic [4:0]                    comp_senone,
    output logic [IDX_W-1:0]              comp_idx,
    output logic                          comp_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COMPONENTS - 1);

    state_t                          state_q, state_d;
    logic [4:0]                      rom_index_q, rom_index_d;
    logic [4:0]                      last_q, last_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            err_q, err_d;
    logic                            load_en;
    logic [NUM_W-1:0]                k_q;
    logic [N_COMPONENTS*NUM_W-1:0]   omegas_q;
    logic [N_COMPONENTS*NUM_W-1:0]   means_q;
    logic                            range_ok;
    logic                            idx_is_last;
    logic                            xfer;

`ifdef SENONE_SEQ_WRAP_EN
    // Wrapped ranges are legal; the 5-bit index simply rolls over past 31.
    assign range_ok = 1'b1;
`else
    assign range_ok = (first_idx <= last_idx);
`endif

    assign idx_is_last = (idx_q == IDX_LAST);
    assign xfer        = (state_q == STREAM) && comp_ready && !abort;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            rom_index_q <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_index_q <= rom_index_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            k_q      <= '0;
            omegas_q <= '0;
            means_q  <= '0;
        end else if (load_en) begin
            k_q      <= rom_k;
            omegas_q <= rom_omegas;
            means_q  <= rom_means;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rom_index_d = rom_index_q;
        last_d      = last_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        load_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (range_ok) begin
                        last_d      = last_idx;
                        rom_index_d = first_idx;
                        idx_d       = '0;
                        state_d     = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                load_en = 1'b1;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_is_last) begin
                        idx_d = '0;
                        if (rom_index_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            rom_index_d = rom_index_q + 5'd1;
                            state_d     = LOAD;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort wins over everything that could happen in an active state,
        // including a transfer presented in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            rom_index_d = rom_index_q;
            idx_d       = '0;
            load_en     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // comp_valid drops in an abort cycle so the scorer never sees a
    // handshake the sequencer does not count.
    assign comp_valid  = (state_q == STREAM) && !abort;
    assign comp_last   = (state_q == STREAM) && idx_is_last;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE) && !abort;
    assign err         = err_q;
    assign rom_index   = rom_index_q;
    assign comp_senone = rom_index_q;
    assign comp_idx    = idx_q;
    assign comp_k      = k_q;

    always_comb begin
        comp_omega = '0;
        comp_mean  = '0;
        for (int c = 0; c < N_COMPONENTS; c++) begin
            if (idx_q == IDX_W'(c)) begin
                comp_omega = omegas_q[c*NUM_W +: NUM_W];
                comp_mean  = means_q[c*NUM_W +: NUM_W];
            end
        end
    end

endmodule

// File: tb/tb_senone_sequencer.sv
// tb_senone_sequencer
//   Randomized bench for senone_sequencer with N_COMPONENTS=4, NUM_W=16.
//   Expected beats come from a list of (senone, component) pairs built from
//   the range rules and a ROM table owned by the bench.
module tb_senone_sequencer;

    localparam int NC = 4;
    localparam int NW = 16;
`ifdef SENONE_SEQ_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic            clk;
    logic            nReset;
    logic            start;
    logic            abort;
    logic [4:0]      first_idx;
    logic [4:0]      last_idx;
    logic [4:0]      rom_index;
    logic [NW-1:0]   rom_k;
    logic [NC*NW-1:0] rom_omegas;
    logic [NC*NW-1:0] rom_means;
    logic            comp_valid;
    logic            comp_ready;
    logic [NW-1:0]   comp_k;
    logic [NW-1:0]   comp_omega;
    logic [NW-1:0]   comp_mean;
    logic [4:0]      comp_senone;
    logic [1:0]      comp_idx;
    logic            comp_last;
    logic            busy;
    logic            done;
    logic            err;

    senone_sequencer #(.N_COMPONENTS(NC), .NUM_W(NW)) dut (
        .clk(clk), .nReset(nReset), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .rom_index(rom_index),
        .rom_k(rom_k), .rom_omegas(rom_omegas), .rom_means(rom_means),
        .comp_valid(comp_valid), .comp_ready(comp_ready),
        .comp_k(comp_k), .comp_omega(comp_omega), .comp_mean(comp_mean),
        .comp_senone(comp_senone), .comp_idx(comp_idx), .comp_last(comp_last),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents
    logic [15:0] rk [32];
    logic [15:0] ro [32][NC];
    logic [15:0] rm [32][NC];

    always_comb begin
        rom_k      = rk[rom_index];
        rom_omegas = '0;
        rom_means  = '0;
        for (int c = 0; c < NC; c++) begin
            rom_omegas[c*NW +: NW] = ro[rom_index][c];
            rom_means[c*NW +: NW]  = rm[rom_index][c];
        end
    end

    typedef struct {
        logic [4:0]  senone;
        logic [1:0]  idx;
        logic [15:0] k;
        logic [15:0] omega;
        logic [15:0] mean;
        logic        last;
    } beat_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = 3-cycle stall on beat 2
    task automatic run(input logic [4:0] f, input logic [4:0] l, input int mode,
                       input bit do_abort);
        beat_t      q[$];
        beat_t      b;
        logic [4:0] s;
        logic [4:0] abort_sen;
        int  nsen = 0;
        bit  expect_err;
        int  busy_cyc = 0, stalls = 0, bubbles = 0, dones = 0, errs = 0;
        int  stall_left = 3;
        bit  finished = 1'b0;
        bit  aborted = 1'b0;
        bit  abort_now;

        expect_err = !WRAP && (f > l);
        abort_sen  = f + 5'd1;
        if (!expect_err) begin
            s = f;
            for (int n = 0; n < 32; n++) begin
                nsen++;
                for (int c = 0; c < NC; c++) begin
                    b.senone = s;
                    b.idx    = 2'(c);
                    b.k      = rk[s];
                    b.omega  = ro[s][c];
                    b.mean   = rm[s][c];
                    b.last   = (c == NC - 1);
                    q.push_back(b);
                end
                if (s == l) break;
                s = s + 5'd1;
            end
        end

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; comp_ready = 1'b1;
        first_idx = f; last_idx = l;
        @(negedge clk);
        chk("idle_before_start", busy, 0);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(posedge clk); #1;
            abort_now = do_abort && !aborted && q.size() > 0 &&
                        q[0].senone == abort_sen && q[0].idx == 2'd2;
            if (expect_err || aborted || abort_now) begin
                start = 1'b0;
            end else begin
                start = ($urandom_range(0, 3) == 0);
                first_idx = 5'($urandom);
                last_idx  = 5'($urandom);
            end
            abort = abort_now;
            case (mode)
                0: comp_ready = 1'b1;
                1: comp_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (q.size() > 0 && q[0].idx == 2'd1 && stall_left > 0) begin
                        comp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        comp_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) dones++;
            if (err)  errs++;
            if (aborted) begin
                chk("abort_valid", comp_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                finished = 1'b1;
            end else if (comp_valid) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("senone", comp_senone, q[0].senone);
                    chk("idx",    comp_idx,    q[0].idx);
                    chk("k",      comp_k,      q[0].k);
                    chk("omega",  comp_omega,  q[0].omega);
                    chk("mean",   comp_mean,   q[0].mean);
                    chk("last",   comp_last,   q[0].last);
                    if (comp_ready && !abort) void'(q.pop_front());
                    else if (!abort) stalls++;
                end
            end else if (busy) begin
                bubbles++;
            end
            if (abort_now) aborted = 1'b1;
            if (done) begin
                chk("done_with_beats_left", q.size(), 0);
                finished = 1'b1;
            end
            if (expect_err && cyc >= 4) finished = 1'b1;
        end

        if (expect_err) begin
            chk("err_pulses", errs, 1);
            chk("err_busy", busy_cyc, 0);
            chk("err_done", dones, 0);
        end else if (do_abort) begin
            chk("abort_reached", aborted, 1);
            chk("abort_no_done", dones, 0);
        end else begin
            chk("run_finished", finished, 1);
            chk("beats_left", q.size(), 0);
            chk("done_pulses", dones, 1);
            chk("busy_cycles", busy_cyc, nsen * (NC + 1) + 1 + stalls);
            chk("bubbles", bubbles, nsen + 1);
            chk("no_err", errs, 0);
        end

        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_after_run", busy, 0);
        chk("idle_valid", comp_valid, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"},  comp_valid, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_err"},    err, 0);
        chk({tag, "_last"},   comp_last, 0);
        chk({tag, "_index"},  rom_index, 0);
        chk({tag, "_idx"},    comp_idx, 0);
        chk({tag, "_k"},      comp_k, 0);
        chk({tag, "_omega"},  comp_omega, 0);
        chk({tag, "_mean"},   comp_mean, 0);
    endtask

    initial begin
        logic [4:0] f, l;
        int dones;
        nReset = 1'b0; start = 1'b0; abort = 1'b0; comp_ready = 1'b0;
        first_idx = '0; last_idx = '0;

        for (int s = 0; s < 32; s++) begin
            rk[s] = 16'($urandom);
            for (int c = 0; c < NC; c++) begin
                ro[s][c] = 16'($urandom);
                rm[s][c] = 16'($urandom);
            end
        end
        rk[0] = 16'h17C5;
        ro[0][0] = 16'h002B; ro[0][1] = 16'h0014; ro[0][2] = 16'h0010; ro[0][3] = 16'h0011;
        rm[0][0] = 16'h17A3; rm[0][1] = 16'h0EF7; rm[0][2] = 16'hF9E4; rm[0][3] = 16'hFADD;

        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1 nReset = 1'b1;

        run(5'd0, 5'd0, 0, 1'b0);         // single senone, row 0
        run(5'd0, 5'd2, 0, 1'b0);         // three senones back to back
        run(5'd0, 5'd0, 2, 1'b0);         // backpressure on beat 2
        run(5'd0, 5'd2, 0, 1'b1);         // abort on beat 3 of senone 1
        run(5'd3, 5'd4, 0, 1'b0);         // normal run after abort
        run(5'd30, 5'd1, 1, 1'b0);        // wrap or err depending on build
        run(5'd31, 5'd31, 1, 1'b0);       // top index, single senone

        for (int i = 0; i < 6; i++) begin
            f = 5'($urandom);
            if (WRAP) l = f + 5'($urandom_range(0, 3));
            else      l = (int'(f) + 2 > 31) ? 5'd31 : f + 5'($urandom_range(0, 2));
            run(f, l, 1, 1'b0);
        end

        // reset in the middle of a stream
        @(posedge clk); #1;
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd1; comp_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 nReset = 1'b0;
        #1 check_outputs_zero("midreset");
        @(posedge clk); #1 nReset = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("midreset_quiet", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
